qrisc32_bus_arb: RTL and testbench
==================================

// Module: qrisc32_bus_arb
// PURPOSE
//  Shares the single external memory port between instruction fetch (IF) and the data
//  access stage (MEM, address from EX val_r1). Two-requester round-robin arbiter with a
//  one-transaction-at-a-time FSM, per-transaction timeout, and generation of pipe_stall
//  for the pipeline while a data access is outstanding. Sits between the stages and the bus.
// PARAMETERS
//  AW        32  address width
//  DW        32  data width
//  MAX_WAIT  15  bus cycles in BUSY before timeout; legal range 1..255
// PORTS
//  clk          in   1   clock; all logic on rising edge
//  reset        in   1   synchronous, active-high reset
//  if_req       in   1   IF read request; held with if_addr until if_ack
//  if_addr      in   AW  IF read address
//  if_ack       out  1   1-cycle pulse: if_rdata valid
//  if_rdata     out  DW  fetched word
//  flush        in   1   EX new_address_valid; cancels in-flight IF result
//  dm_req       in   1   MEM request; held with dm_we/addr/wdata until dm_ack
//  dm_we        in   1   1 = write, 0 = read
//  dm_addr      in   AW  data address
//  dm_wdata     in   DW  write data
//  dm_ack       out  1   1-cycle pulse: access done, dm_rdata valid on reads
//  dm_rdata     out  DW  read data
//  pipe_stall   out  1   stall to pipeline stages
//  bus_req      out  1   external request, held until bus_ack
//  bus_we       out  1   external write enable
//  bus_addr     out  AW  external address
//  bus_wdata    out  DW  external write data
//  bus_ack      in   1   external completion; bus_rdata valid same cycle
//  bus_rdata    in   DW  external read data
//  bus_err      out  1   1-cycle pulse on timeout
// BEHAVIOUR
//  Reset: state IDLE, last_gnt=IF (data wins first tie), all outputs 0, wait_cnt 0.
//  States: IDLE, BUSY_I, BUSY_D. Only one bus transaction outstanding.
//  IDLE: eligible = req & ~(ack of same requester this cycle) (masks held-req re-grant).
//   one eligible -> grant it; both -> grant the one not in last_gnt; none -> stay.
//   Grant edge: bus_req<=1, bus_addr/we/wdata registered from winner (IF: we=0, wdata=0),
//   last_gnt<=winner, wait_cnt<=0, state<=BUSY_I/BUSY_D.
//  BUSY_x: bus_* held stable. bus_ack=1 -> bus_req<=0, latch bus_rdata into x_rdata,
//   x_ack<=1 next cycle, state<=IDLE. Else wait_cnt++; wait_cnt==MAX_WAIT-1 with no
//   bus_ack -> timeout: bus_req<=0, bus_err<=1, x_ack<=1, x_rdata<=0, state<=IDLE.
//  Latency: req sampled cycle 0 in IDLE -> bus_req cycle 1 -> bus_ack cycle k ->
//   x_ack cycle k+1; next grant decided cycle k+1, bus_req again cycle k+2.
//  flush: asserted any cycle of BUSY_I (or same cycle as grant to IF) sets cancel flag;
//   transaction still completes on bus, if_ack suppressed, if_rdata unchanged; flag
//   cleared on return to IDLE. flush in IDLE has no effect.
//  pipe_stall = dm_req & ~dm_ack (combinational). IF waiting never stalls via this port.
//  bus_ack in IDLE ignored. bus_ack and timeout same cycle: bus_ack wins, no bus_err.
//  x_rdata held between acks. dm_rdata on writes = last read value (unchanged).
//  reset mid-transaction: bus_req dropped next edge, no ack to either requester.
// STRUCTURE
//  risc_pack additions: typedef enum logic[1:0] {ARB_IDLE,ARB_BUSY_I,ARB_BUSY_D}
//   arb_state_t; typedef enum logic {GNT_IF,GNT_DM} arb_gnt_t.
//  Sub-module qrisc32_rr_pick2: combinational 2-way pick (req[1:0], last -> gnt[1:0]).
//  wait_cnt width $clog2(MAX_WAIT+1).
// TESTING
//  dm_req read addr 0x100, bus_ack 2 cycles after bus_req, rdata 0xCAFE0001 ->
//   bus_addr=0x100, dm_ack at k+1, dm_rdata=0xCAFE0001, pipe_stall high until dm_ack.
//  if_req and dm_req both held from reset, bus_ack 1 cycle -> grant order D,I,D,I;
//   no requester granted twice in a row; held req not re-granted in its ack cycle.
//  dm_req write addr 0x20 data 0x12345678 -> bus_we=1, bus_wdata=0x12345678, dm_ack once.
//  IF grant, flush in 2nd BUSY_I cycle, bus_ack later -> no if_ack, if_rdata unchanged,
//   next grant proceeds normally.
//  MAX_WAIT=4, no bus_ack -> bus_req drops after 4 BUSY cycles, bus_err and ack pulse,
//   rdata=0; bus_ack in same cycle as timeout -> normal completion, no bus_err.
//  reset asserted during BUSY_D -> next edge bus_req=0, dm_ack=0, state IDLE.

Source files
------------

// File: rtl/qrisc32_bus_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qrisc32_bus_arb_pkg
//  Description : Shared types for the qrisc32 memory-port arbiter.
//                arb_state_t - arbiter FSM states
//                arb_gnt_t   - identity of the most recently granted requester
//                c_REQ_IF / c_REQ_DM - bit positions in the 2-bit request vectors
//  Revision    : 1.0 - initial release
// ============================================================================
package qrisc32_bus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } arb_gnt_t;

    // Bit positions of each requester in the 2-bit request/grant vectors
    localparam int c_REQ_IF = 0;
    localparam int c_REQ_DM = 1;

endpackage
`default_nettype wire

// File: rtl/qrisc32_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : qrisc32_rr_pick2
//  Description : Combinational two-way round-robin pick.
//                i_req[1:0] - eligible requesters (bit0 = IF, bit1 = DM)
//                i_last     - requester granted most recently
//                o_gnt[1:0] - one-hot grant (all zero when nothing requests)
//  Revision    : 1.0 - initial release
// ============================================================================
module qrisc32_rr_pick2
    import qrisc32_bus_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  arb_gnt_t   i_last,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            // On a tie the requester that did not win last time goes first
            2'b11:   o_gnt = (i_last == GNT_IF) ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/qrisc32_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module      : qrisc32_bus_arb
//  Description : Shares the single external memory port between instruction
//                fetch (IF) and the data stage (MEM). Round-robin grant, one
//                bus transaction at a time, per-transaction timeout, and
//                pipe_stall while a data access is outstanding.
//  Ports       : clk/reset          - clock, synchronous active-high reset
//                if_req/addr/ack/rdata, flush - fetch side
//                dm_req/we/addr/wdata/ack/rdata - data side
//                pipe_stall         - stall to pipeline stages
//                bus_req/we/addr/wdata/ack/rdata/err - external bus
//  Revision    : 1.0 - initial release
// ============================================================================
module qrisc32_bus_arb
    import qrisc32_bus_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 15
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          flush,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          pipe_stall,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ack,
    input  logic [DW-1:0] bus_rdata,
    output logic          bus_err
);

    localparam int              c_CW        = $clog2(MAX_WAIT + 1);
    localparam logic [c_CW-1:0] c_WAIT_LAST = c_CW'(MAX_WAIT - 1);

    arb_state_t      r_state;
    arb_state_t      w_state_next;
    arb_gnt_t        r_last_gnt;
    logic [c_CW-1:0] r_wait_cnt;
    logic            r_cancel;
    logic [1:0]      w_elig;
    logic [1:0]      w_gnt;
    logic            w_timeout;
    logic            w_if_cancel;

    // A requester still holding req during its own ack cycle must not be
    // granted again for the transaction that just finished.
    assign w_elig[c_REQ_IF] = if_req & ~if_ack;
    assign w_elig[c_REQ_DM] = dm_req & ~dm_ack;

    // Flush in the completion cycle itself also cancels the fetch result
    assign w_if_cancel = r_cancel | flush;

    assign pipe_stall = dm_req & ~dm_ack;

    qrisc32_rr_pick2 u_pick (
        .i_req  (w_elig),
        .i_last (r_last_gnt),
        .o_gnt  (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_gnt[c_REQ_DM]) begin
                    w_state_next = ARB_BUSY_D;
                end else if (w_gnt[c_REQ_IF]) begin
                    w_state_next = ARB_BUSY_I;
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                // bus_ack has priority over a coincident timeout
                if (bus_ack) begin
                    w_state_next = ARB_IDLE;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = ARB_IDLE;
                end
            end
            default: w_state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_gnt <= GNT_IF;
            r_wait_cnt <= '0;
            r_cancel   <= 1'b0;
            if_ack     <= 1'b0;
            if_rdata   <= '0;
            dm_ack     <= 1'b0;
            dm_rdata   <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_err    <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            dm_ack  <= 1'b0;
            bus_err <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    r_cancel <= 1'b0;
                    if (w_gnt != 2'b00) begin
                        bus_req    <= 1'b1;
                        r_wait_cnt <= '0;
                        if (w_gnt[c_REQ_DM]) begin
                            bus_we     <= dm_we;
                            bus_addr   <= dm_addr;
                            bus_wdata  <= dm_wdata;
                            r_last_gnt <= GNT_DM;
                        end else begin
                            bus_we     <= 1'b0;
                            bus_addr   <= if_addr;
                            bus_wdata  <= '0;
                            r_last_gnt <= GNT_IF;
                            r_cancel   <= flush;
                        end
                    end
                end
                ARB_BUSY_I, ARB_BUSY_D: begin
                    if (bus_ack || w_timeout) begin
                        bus_req <= 1'b0;
                        bus_err <= w_timeout;
                        if (r_state == ARB_BUSY_I) begin
                            // Cancelled fetch: bus cycle completes silently
                            if (!w_if_cancel) begin
                                if_ack   <= 1'b1;
                                if_rdata <= bus_ack ? bus_rdata : '0;
                            end
                        end else begin
                            dm_ack <= 1'b1;
                            if (!bus_ack) begin
                                dm_rdata <= '0;
                            end else if (!bus_we) begin
                                dm_rdata <= bus_rdata;
                            end
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                        if ((r_state == ARB_BUSY_I) && flush) begin
                            r_cancel <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qrisc32_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qrisc32_bus_arb
//  Description : Self-checking bench for qrisc32_bus_arb. Stimulus tasks push
//                expected bus transactions and acks into queues; a monitor
//                pops and compares whenever the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qrisc32_bus_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, flush, dm_req, dm_we, bus_ack;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata, bus_rdata;
    logic          if_ack, dm_ack, pipe_stall, bus_req, bus_we, bus_err;
    logic [DW-1:0] if_rdata, dm_rdata, bus_wdata;
    logic [AW-1:0] bus_addr;

    qrisc32_bus_arb #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ack     (if_ack),
        .if_rdata   (if_rdata),
        .flush      (flush),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_ack     (dm_ack),
        .dm_rdata   (dm_rdata),
        .pipe_stall (pipe_stall),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .bus_err    (bus_err)
    );

    initial forever #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } bus_exp_t;
    typedef struct { logic [31:0] rdata; logic err; } ack_exp_t;

    bus_exp_t q_bus[$];
    ack_exp_t q_dm[$];
    ack_exp_t q_if[$];

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic void fail_evt(string name);
        checks++;
        errors++;
        $display("FAIL %s actual=1 required=0", name);
    endfunction

    // ---------------- bus responder: ack ack_delay cycles after bus_req ----
    int          ack_delay = -1;
    logic [31:0] resp_data = '0;
    int          bus_cnt   = 0;

    initial begin
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_req && !bus_ack) begin
                bus_cnt++;
                if (ack_delay >= 0 && bus_cnt == ack_delay + 1) begin
                    bus_ack   = 1'b1;
                    bus_rdata = resp_data;
                end
            end else begin
                bus_ack = 1'b0;
                bus_cnt = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ---------------------------------
    logic     prev_req = 1'b0;
    bus_exp_t mb;
    ack_exp_t ma;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_req = 1'b0;
            end else begin
                if (bus_req && !prev_req) begin
                    if (q_bus.size() == 0) begin
                        fail_evt("unexpected_bus_req");
                    end else begin
                        mb = q_bus.pop_front();
                        chk("bus_addr",  bus_addr,  mb.addr);
                        chk("bus_we",    bus_we,    mb.we);
                        chk("bus_wdata", bus_wdata, mb.wdata);
                    end
                end
                prev_req = bus_req;
                if (dm_ack) begin
                    if (q_dm.size() == 0) begin
                        fail_evt("unexpected_dm_ack");
                    end else begin
                        ma = q_dm.pop_front();
                        chk("dm_rdata", dm_rdata, ma.rdata);
                        chk("dm_err",   bus_err,  ma.err);
                    end
                end
                if (if_ack) begin
                    if (q_if.size() == 0) begin
                        fail_evt("unexpected_if_ack");
                    end else begin
                        ma = q_if.pop_front();
                        chk("if_rdata", if_rdata, ma.rdata);
                        chk("if_err",   bus_err,  ma.err);
                    end
                end
                if (bus_err && !dm_ack && !if_ack) fail_evt("unexpected_bus_err");
            end
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        bus_exp_t b;
        ack_exp_t a;
        int       n;
        logic     got;
        b.addr = addr; b.we = we; b.wdata = wdata;
        a.rdata = exp_rdata; a.err = exp_err;
        q_bus.push_back(b);
        q_dm.push_back(a);
        dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_req = 1'b1;
        #1;
        chk("pipe_stall_req", pipe_stall, 1'b1);
        n = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (dm_ack) got = 1'b1;
        end
        if (!got) begin
            fail_evt("dm_ack_timeout");
        end else begin
            chk("dm_latency",     n,          exp_lat);
            chk("pipe_stall_ack", pipe_stall, 1'b0);
            chk("bus_req_done",   bus_req,    1'b0);
        end
        dm_req = 1'b0;
    endtask

    task automatic do_if(input logic [31:0] addr, input logic [31:0] exp_rdata, input int exp_lat);
        bus_exp_t b;
        ack_exp_t a;
        int       n;
        logic     got;
        b.addr = addr; b.we = 1'b0; b.wdata = '0;
        a.rdata = exp_rdata; a.err = 1'b0;
        q_bus.push_back(b);
        q_if.push_back(a);
        if_addr = addr; if_req = 1'b1;
        n = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clk);
            #1;
            n++;
            chk("if_no_stall", pipe_stall, 1'b0);
            if (if_ack) got = 1'b1;
        end
        if (!got) fail_evt("if_ack_timeout");
        else chk("if_latency", n, exp_lat);
        if_req = 1'b0;
    endtask

    // ---------------- main sequence -----------------------------------------
    bus_exp_t sb;
    ack_exp_t sa;

    initial begin
        int dmc, ifc, n;
        reset = 1'b1;
        if_req = 0; if_addr = 0; flush = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        idle(3);
        chk("rst_if_ack",    if_ack,    1'b0);
        chk("rst_if_rdata",  if_rdata,  32'h0);
        chk("rst_dm_ack",    dm_ack,    1'b0);
        chk("rst_dm_rdata",  dm_rdata,  32'h0);
        chk("rst_bus_req",   bus_req,   1'b0);
        chk("rst_bus_we",    bus_we,    1'b0);
        chk("rst_bus_addr",  bus_addr,  32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_err",   bus_err,   1'b0);
        chk("rst_stall",     pipe_stall, 1'b0);
        reset = 1'b0;
        idle(2);

        // Data read, bus_ack 2 cycles after bus_req
        ack_delay = 2; resp_data = 32'hCAFE0001;
        do_dm(1'b0, 32'h100, 32'h0, 32'hCAFE0001, 1'b0, 4);
        idle(2);

        // Data write; dm_rdata keeps the last read value
        ack_delay = 1; resp_data = 32'h55555555;
        do_dm(1'b1, 32'h20, 32'h12345678, 32'hCAFE0001, 1'b0, 3);
        idle(2);

        // Plain fetch
        resp_data = 32'h11110000;
        do_if(32'h40, 32'h11110000, 3);
        idle(2);

        // Both held: D, I, D, I
        resp_data = 32'hA0A0A0A0;
        for (int i = 0; i < 2; i++) begin
            sb.addr = 32'h200; sb.we = 1'b0; sb.wdata = '0; q_bus.push_back(sb);
            sb.addr = 32'h400;                              q_bus.push_back(sb);
            sa.rdata = 32'hA0A0A0A0; sa.err = 1'b0;
            q_dm.push_back(sa);
            q_if.push_back(sa);
        end
        dm_we = 0; dm_addr = 32'h200; dm_wdata = 0; if_addr = 32'h400;
        dm_req = 1; if_req = 1;
        dmc = 0; ifc = 0; n = 0;
        while ((dmc < 2 || ifc < 2) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (dm_ack) begin dmc++; if (dmc == 2) dm_req = 0; end
            if (if_ack) begin ifc++; if (ifc == 2) if_req = 0; end
        end
        dm_req = 0; if_req = 0;
        chk("rr_dm_acks", dmc, 2);
        chk("rr_if_acks", ifc, 2);
        idle(3);

        // Fetch cancelled by flush in the 2nd BUSY_I cycle
        ack_delay = 3; resp_data = 32'hDEADBEEF;
        sb.addr = 32'h500; sb.we = 1'b0; sb.wdata = '0; q_bus.push_back(sb);
        if_addr = 32'h500; if_req = 1;
        idle(1);
        chk("flush_bus_req", bus_req, 1'b1);
        idle(1);
        flush = 1; if_req = 0;
        idle(1);
        flush = 0;
        n = 0;
        while (bus_req && n < 20) begin idle(1); n++; end
        if (bus_req) fail_evt("flush_bus_stuck");
        idle(3);
        chk("flush_if_rdata", if_rdata, 32'hA0A0A0A0);
        resp_data = 32'h22220000; ack_delay = 1;
        do_if(32'h504, 32'h22220000, 3);
        idle(2);

        // Timeout with no bus_ack
        ack_delay = -1;
        do_dm(1'b0, 32'h300, 32'h0, 32'h0, 1'b1, 5);
        idle(2);

        // bus_ack in the timeout cycle: normal completion
        ack_delay = 3; resp_data = 32'h77770000;
        do_dm(1'b0, 32'h304, 32'h0, 32'h77770000, 1'b0, 5);
        idle(2);

        // Reset during BUSY_D
        ack_delay = -1;
        sb.addr = 32'h600; sb.we = 1'b0; sb.wdata = '0; q_bus.push_back(sb);
        dm_we = 0; dm_addr = 32'h600; dm_req = 1;
        idle(2);
        chk("pre_rst_bus_req", bus_req, 1'b1);
        reset = 1; dm_req = 0;
        idle(1);
        chk("mid_rst_bus_req", bus_req, 1'b0);
        chk("mid_rst_dm_ack",  dm_ack,  1'b0);
        chk("mid_rst_bus_err", bus_err, 1'b0);
        reset = 0;
        idle(6);
        chk("post_rst_bus_req", bus_req, 1'b0);

        chk("q_bus_empty", q_bus.size(), 0);
        chk("q_dm_empty",  q_dm.size(),  0);
        chk("q_if_empty",  q_if.size(),  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
